// File: rtl/note_judge.sv
`default_nettype none
// ============================================================================
// Module   : note_judge
// Purpose  : Rhythm-game note highway and strike judge. Chart notes enter
//            row 0 on every eighth-note step and scroll toward the strike
//            row (DEPTH-1). A strum is judged against the strike row. Hits
//            build a streak, a multiplier and a score; misses clear the streak.
// Ports    : clk        - single clock, posedge
//            reset      - synchronous active-high reset
//            eight_beat - one-cycle pulse per eighth-note step
//            exp_notes  - chart notes entering row 0 (bit per fret)
//            frets      - fret buttons currently held
//            strum      - one-cycle strum pulse
//            highway    - all rows, row i at [5i+4:5i]; a judged strike row
//                         reads as zero
//            hit/miss   - one-cycle judgement pulses
//            score      - accumulated points, saturating at 16'hFFFF
//            streak     - consecutive hits, saturating at 255
//            mult       - current multiplier 1..4
// Config   : NOTE_JUDGE_OVERSTRUM_EN - when defined, a strum on an empty
//            strike row counts as a miss; otherwise it is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module note_judge #(
  parameter int DEPTH = 8,
  parameter int PTS   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               eight_beat,
  input  logic [4:0]         exp_notes,
  input  logic [4:0]         frets,
  input  logic               strum,
  output logic [5*DEPTH-1:0] highway,
  output logic               hit,
  output logic               miss,
  output logic [15:0]        score,
  output logic [7:0]         streak,
  output logic [2:0]         mult
);

  localparam logic [31:0] c_PTS32 = 32'(PTS);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    JUDGED  = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  rows_q [DEPTH];
  logic        hit_q;
  logic        miss_q;
  logic [15:0] score_q;
  logic [7:0]  streak_q;

  logic        w_judge;
  logic        w_over;
  logic        hit_d;
  logic        miss_d;
  logic [2:0]  w_mult;
  logic [31:0] w_sum;
  logic [15:0] score_d;
  logic [7:0]  streak_d;

  // streak/8 >= 3 exactly when streak >= 24
  always_comb begin
    w_mult = 3'd1;
    if ((streak_q[7:5] != 3'd0) || (streak_q[4:3] == 2'b11)) begin
      w_mult = 3'd4;
    end else begin
      w_mult = {1'b0, streak_q[4:3]} + 3'd1;
    end
  end

  always_comb begin
    w_judge = strum && (state_q == PENDING);
`ifdef NOTE_JUDGE_OVERSTRUM_EN
    w_over  = strum && (state_q == EMPTY);
`else
    w_over  = 1'b0;
`endif
    hit_d   = w_judge && (frets == rows_q[DEPTH-1]);
    // A strum in the beat cycle is judged instead of the pass-through miss,
    // so a single note can never produce two misses.
    miss_d  = (w_judge && !hit_d) || w_over ||
              (eight_beat && (state_q == PENDING) && !strum);

    // Points use the multiplier from before this hit's streak increment.
    w_sum   = {16'd0, score_q} + (c_PTS32 * {29'd0, w_mult});
    score_d = score_q;
    if (hit_d) begin
      score_d = (w_sum > 32'h0000_FFFF) ? 16'hFFFF : w_sum[15:0];
    end

    streak_d = streak_q;
    if (hit_d) begin
      streak_d = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
    end else if (miss_d) begin
      streak_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rows_q[i] <= 5'd0;
      end
      state_q  <= EMPTY;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= 16'd0;
      streak_q <= 8'd0;
    end else begin
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      if (eight_beat) begin
        // Shift wins over the judge: the judged row leaves the highway anyway.
        rows_q[0] <= exp_notes;
        for (int i = 1; i < DEPTH; i++) begin
          rows_q[i] <= rows_q[i-1];
        end
        state_q <= (rows_q[DEPTH-2] != 5'd0) ? PENDING : EMPTY;
      end else if (w_judge) begin
        // Clearing the judged note makes it vanish from the display.
        rows_q[DEPTH-1] <= 5'd0;
        state_q         <= JUDGED;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hwy
    assign highway[5*gi +: 5] = rows_q[gi];
  end

  assign hit    = hit_q;
  assign miss   = miss_q;
  assign score  = score_q;
  assign streak = streak_q;
  assign mult   = w_mult;

endmodule
`default_nettype wire

// File: tb/tb_note_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_judge
// Purpose  : Directed self-checking bench for note_judge (DEPTH=8, PTS=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_judge;

  logic        clk;
  logic        reset;
  logic        eight_beat;
  logic [4:0]  exp_notes;
  logic [4:0]  frets;
  logic        strum;
  logic [39:0] highway;
  logic        hit;
  logic        miss;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [2:0]  mult;

  int checks = 0;
  int errors = 0;

  note_judge #(.DEPTH(8), .PTS(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .eight_beat (eight_beat),
    .exp_notes  (exp_notes),
    .frets      (frets),
    .strum      (strum),
    .highway    (highway),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .streak     (streak),
    .mult       (mult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Apply inputs for one clock edge; outputs are observed 1 ns after it.
  task automatic step(input logic b, input logic [4:0] e, input logic s, input logic [4:0] f);
    eight_beat = b;
    exp_notes  = e;
    strum      = s;
    frets      = f;
    @(posedge clk);
    #1;
    eight_beat = 1'b0;
    strum      = 1'b0;
  endtask

  logic [4:0] c_HIT  = 5'b00111;
  logic [4:0] c_BAD  = 5'b01011;
  logic       over_exp;
  int         es;
  int         esc;
  int         em;

  initial begin
`ifdef NOTE_JUDGE_OVERSTRUM_EN
    over_exp = 1'b1;
`else
    over_exp = 1'b0;
`endif
    reset = 1'b1; eight_beat = 1'b0; exp_notes = 5'd0; frets = 5'd0; strum = 1'b0;
    step(0, 5'd0, 0, 5'd0);
    step(0, 5'd0, 0, 5'd0);
    check("rst_highway", 64'(highway), 64'd0);
    check("rst_hit",     64'(hit),     64'd0);
    check("rst_miss",    64'(miss),    64'd0);
    check("rst_score",   64'(score),   64'd0);
    check("rst_streak",  64'(streak),  64'd0);
    check("rst_mult",    64'(mult),    64'd1);
    reset = 1'b0;

    // Fill the highway with 00111, then hit the strike row.
    for (int i = 0; i < 8; i++) step(1, c_HIT, 0, 5'd0);
    check("fill_highway", 64'(highway), 64'({8{5'b00111}}));
    check("fill_nomiss",  64'(miss),    64'd0);
    step(0, 5'd0, 1, c_HIT);
    check("hit1_hit",    64'(hit),            64'd1);
    check("hit1_miss",   64'(miss),           64'd0);
    check("hit1_score",  64'(score),          64'd10);
    check("hit1_streak", 64'(streak),         64'd1);
    check("hit1_strike", 64'(highway[39:35]), 64'd0);
    step(0, 5'd0, 0, 5'd0);
    check("hit1_pulse_end", 64'(hit), 64'd0);
    step(0, 5'd0, 1, c_HIT);
    check("judged_strum_hit",   64'(hit),   64'd0);
    check("judged_strum_miss",  64'(miss),  64'd0);
    check("judged_strum_score", 64'(score), 64'd10);

    // Hits 2..8 at mult 1; multiplier steps to 2 after the 8th.
    for (int k = 2; k <= 8; k++) begin
      step(1, c_HIT, 0, 5'd0);
      step(0, 5'd0, 1, c_HIT);
    end
    check("hit8_streak", 64'(streak), 64'd8);
    check("hit8_score",  64'(score),  64'd80);
    check("hit8_mult",   64'(mult),   64'd2);
    step(1, c_HIT, 0, 5'd0);
    step(0, 5'd0, 1, c_HIT);
    check("hit9_score",  64'(score),  64'd100);
    check("hit9_streak", 64'(streak), 64'd9);

    // Strum coincident with the beat: judge pre-shift row, then shift.
    step(1, c_HIT, 0, 5'd0);
    check("pre_same_nomiss", 64'(miss), 64'd0);
    step(1, c_HIT, 1, c_HIT);
    check("same_hit",     64'(hit),     64'd1);
    check("same_miss",    64'(miss),    64'd0);
    check("same_score",   64'(score),   64'd120);
    check("same_streak",  64'(streak),  64'd10);
    check("same_highway", 64'(highway), 64'({8{5'b00111}}));
    step(0, 5'd0, 0, 5'd0);
    check("same_after_hit",  64'(hit),  64'd0);
    check("same_after_miss", 64'(miss), 64'd0);

    // Pending note scrolls past unplayed.
    step(1, 5'd0, 0, 5'd0);
    check("pass_miss",   64'(miss),   64'd1);
    check("pass_hit",    64'(hit),    64'd0);
    check("pass_streak", 64'(streak), 64'd0);
    check("pass_score",  64'(score),  64'd120);
    check("pass_mult",   64'(mult),   64'd1);
    step(0, 5'd0, 0, 5'd0);
    check("pass_pulse_end", 64'(miss), 64'd0);

    // Reset mid-song beats a simultaneous beat and matching strum.
    reset = 1'b1;
    step(1, c_BAD, 1, c_HIT);
    check("midrst_highway", 64'(highway), 64'd0);
    check("midrst_hit",     64'(hit),     64'd0);
    check("midrst_miss",    64'(miss),    64'd0);
    check("midrst_score",   64'(score),   64'd0);
    check("midrst_streak",  64'(streak),  64'd0);
    check("midrst_mult",    64'(mult),    64'd1);
    reset = 1'b0;

    // Wrong frets against 01011, then a correct second strum is ignored.
    step(1, c_BAD, 0, 5'd0);
    for (int i = 0; i < 7; i++) step(1, 5'd0, 0, 5'd0);
    check("bad_nomiss_fill", 64'(miss),    64'd0);
    check("bad_highway",     64'(highway), 64'({5'b01011, 35'd0}));
    step(0, 5'd0, 1, c_HIT);
    check("bad_miss",    64'(miss),    64'd1);
    check("bad_hit",     64'(hit),     64'd0);
    check("bad_streak",  64'(streak),  64'd0);
    check("bad_score",   64'(score),   64'd0);
    check("bad_display", 64'(highway), 64'd0);
    step(0, 5'd0, 1, c_BAD);
    check("bad_second_hit",  64'(hit),  64'd0);
    check("bad_second_miss", 64'(miss), 64'd0);

    // Beat past a judged row is silent; strum on an empty row.
    step(1, 5'd0, 0, 5'd0);
    check("judged_beat_nomiss", 64'(miss), 64'd0);
    step(0, 5'd0, 1, 5'd0);
    check("empty_strum_miss", 64'(miss), 64'(over_exp));
    check("empty_strum_hit",  64'(hit),  64'd0);

    // Long run: streak and multiplier saturation.
    reset = 1'b1;
    step(0, 5'd0, 0, 5'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1, 5'b11111, 0, 5'd0);
    es = 0; esc = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 5'd0, 1, 5'b11111);
      em  = (es / 8 + 1 > 4) ? 4 : es / 8 + 1;
      esc = (esc + 10 * em > 65535) ? 65535 : esc + 10 * em;
      es  = (es + 1 > 255) ? 255 : es + 1;
      step(1, 5'b11111, 0, 5'd0);
    end
    check("long_streak", 64'(streak), 64'(es));
    check("long_sat",    64'(streak), 64'd255);
    check("long_score",  64'(score),  64'(esc));
    check("long_mult",   64'(mult),   64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
